// File: rtl/urat_frame_tx.sv
// urat_frame_tx: serial transmitter for the 11-bit UART frame word.
// Shifts {start, data[7:0], parity, stop} out MSB-first. Each bit is held
// for CLKS_PER_BIT clocks. The block also flags an even-parity mismatch
// on the accepted frame, but still transmits the frame unchanged.
module urat_frame_tx #(
  parameter int   CLKS_PER_BIT = 4,
  parameter logic IDLE_LEVEL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] frame_in,
  input  logic        frame_valid,
  output logic        frame_ready,
  output logic        tx_out,
  output logic        busy,
  output logic        done,
  output logic        parity_err
);

  localparam int              BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      BIT_LAST  = 4'd10;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t              state;
  logic [10:0]         shreg;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [3:0]          bit_cnt;

  // Bit 11 of the frame word carries nothing for this stage.
  logic unused_frame_msb;
  assign unused_frame_msb = frame_in[11];

  // Handshake and status follow the state register directly.
  assign frame_ready = (state == IDLE);
  assign busy        = (state == SHIFT);

  // Frame acceptance, bit timing and shifting; tx_out is registered so the line never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register, the shift register included, gets a reset value so an aborted frame leaves nothing behind.
      state      <= IDLE;
      shreg      <= '0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      tx_out     <= IDLE_LEVEL;
      done       <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads pre-edge values of shreg and the counters.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_valid) begin
            shreg      <= frame_in[10:0];
            parity_err <= frame_in[1] ^ (^frame_in[9:2]);
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            tx_out     <= frame_in[10];
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              state  <= IDLE;
              tx_out <= IDLE_LEVEL;
              done   <= 1'b1;
            end else begin
              shreg   <= {shreg[9:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
              tx_out  <= shreg[9];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
